mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller directly downstream of the load/store buffer. It also serves the instruction-fetch unit.
- Owns the single byte-wide RAM port and arbitrates between data requests (LSB) and instruction fetches.
- Serialises each access into byte cycles. Returns a one-cycle completion pulse with assembled, extended load data or fetched instruction word.

Parameters:
- ADDR_W, 32, address width of both request ports and RAM port.
- IO_HI, 2'b11, value of addr[17:16] that selects the memory-mapped IO region.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- rdy_in  in  1  global ready; all state frozen when low
- clear  in  1  pipeline flush (misprediction)
- ls_enable  in  1  LSB request valid
- addr  in  32  LSB byte address
- store_val  in  32  store data (low bytes used)
- lsb_type  in  4  LB 0000, LH 0001, LW 0010, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1010
- ls_finished  out  1  LSB access done, one-cycle pulse
- load_val  out  32  extended load result, valid while ls_finished
- if_enable  in  1  fetch request valid
- if_addr  in  32  fetch address
- if_done  out  1  fetch done, one-cycle pulse
- if_data  out  32  instruction word, valid while if_done
- mem_din  in  8  RAM read data, one cycle after mem_a
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  IO FIFO full

Behaviour:
- Reset (async) values:
  - state=IDLE.
  - mem_a=0, mem_dout=0, mem_wr=0.
  - ls_finished=0, if_done=0, load_val=0, if_data=0.
  - Byte counter and flush flag cleared.
- States: IDLE, LOAD, STORE, FETCH. All outputs are registered. No edge acts while rdy_in=0.
- IDLE accept, at edge E0:
  - LSB wins over fetch when both request.
  - Latch base address, type and store_val. Set n = 1/2/4 for B/H/W; fetch uses n=4.
  - mem_a=base from E0. Go to LOAD, STORE or FETCH.
  - Requests are also sampled in the IDLE cycle where ls_finished or if_done is high. This gives back-to-back service; the LSB presents its next entry during that pulse.
- LOAD/FETCH:
  - mem_a steps base, base+1, … base+n-1 on edges E0..E0+n-1. It returns to 0 afterwards.
  - Byte k of mem_din is captured at edge E0+k+1 into bits [8k+7:8k], little-endian.
  - At edge E0+n+1: done pulse high for one cycle, state=IDLE.
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW and fetch are unmodified.
- STORE:
  - At edges E0..E0+n-1: mem_wr=1, mem_a=base+k, mem_dout=store_val[8k+7:8k].
  - At edge E0+n: mem_wr=0, ls_finished=1, state=IDLE.
  - Store to the IO region while io_buffer_full=1: stall before each byte. mem_wr is held 0 and the counter holds until io_buffer_full=0.
- Address arithmetic is 32-bit modulo; wrap past 0xFFFFFFFF goes to 0.
- clear (with rdy_in):
  - LOAD or FETCH in progress is aborted: state=IDLE, no done pulse, mem_a=0.
  - A pending ls_finished or if_done is forced to 0 at that edge.
  - STORE in progress runs to completion, because the store is already committed. Its ls_finished is suppressed.
  - No new request is accepted on the clear edge.
- Reset asserted mid-access: immediate return to reset values. A partial store is not replayed.

Decomposition:
- Shared header, used by lsb and mem_ctrl: access-type defines (LB…SW), IO region constant, byte-count mapping.
- Extension logic is a local function. No sub-module; the block is one FSM.

Test Plan:
- LW at 0x100, RAM bytes 78 56 34 12, accepted E0 → mem_a 0x100..0x103 on cycles 1–4; ls_finished at E0+5; load_val=0x12345678.
- LB at 0x200 with byte 0x80 → load_val=0xFFFFFF80. LBU at the same address → 0x00000080. Each has 2-cycle latency.
- SH 0x1234ABCD to 0x300 → two cycles mem_wr=1, (0x300,CD) then (0x301,AB); ls_finished at E0+2; next LSB request accepted in that pulse cycle.
- ls_enable and if_enable high together in IDLE → LSB access first; fetch starts on the cycle of ls_finished; if_done 5 cycles after its accept.
- clear during cycle 2 of LW → no ls_finished, mem_a=0 next cycle. Clear during SW → all 4 bytes written, ls_finished stays 0.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles → mem_wr held 0; write occurs on the first cycle after full drops; ls_finished one edge later.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller and its requesters:
// access-type encodings, IO region selector and byte-count mapping.
package mem_ctrl_pkg;

    localparam logic [3:0] LS_LB  = 4'b0000;
    localparam logic [3:0] LS_LH  = 4'b0001;
    localparam logic [3:0] LS_LW  = 4'b0010;
    localparam logic [3:0] LS_LBU = 4'b0100;
    localparam logic [3:0] LS_LHU = 4'b0101;
    localparam logic [3:0] LS_SB  = 4'b1000;
    localparam logic [3:0] LS_SH  = 4'b1001;
    localparam logic [3:0] LS_SW  = 4'b1010;

    // addr[17:16] value that selects the memory-mapped IO region
    localparam logic [1:0] IO_REGION_HI = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStore,
        StFetch
    } state_e;

    // Size field of the access type to number of byte cycles
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        logic [2:0] n;
        unique case (size)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic is_store(input logic [3:0] ls_type);
        return ls_type[3];
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request, completion and RAM-port signals of the memory controller.
// master: LSB, fetch unit and RAM side; slave: the controller.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    // LSB port
    logic              ls_enable;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       store_val;
    logic [3:0]        lsb_type;
    logic              ls_finished;
    logic [31:0]       load_val;

    // Instruction fetch port
    logic              if_enable;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;

    // RAM port
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    modport master (
        output ls_enable, addr, store_val, lsb_type,
        output if_enable, if_addr,
        output mem_din, io_buffer_full,
        input  ls_finished, load_val, if_done, if_data,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  ls_enable, addr, store_val, lsb_type,
        input  if_enable, if_addr,
        input  mem_din, io_buffer_full,
        output ls_finished, load_val, if_done, if_data,
        output mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates LSB and fetch requests onto the byte-wide RAM port,
// serialising each access into byte cycles and returning a one-cycle completion pulse.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = IO_REGION_HI
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      clear,
    mem_ctrl_if.slave bus
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_mem_a;
    logic [3:0]        r_type;
    logic [31:0]       r_store_val;
    logic [31:0]       r_data;
    logic [31:0]       r_load_val;
    logic [31:0]       r_if_data;
    logic [2:0]        r_cnt;
    logic [2:0]        r_len;
    logic [7:0]        r_mem_dout;
    logic              r_mem_wr;
    logic              r_ls_finished;
    logic              r_if_done;
    logic              r_flush;

    logic              w_req_io_full;
    logic              w_store_stall;
    logic [1:0]        w_cap_idx;
    logic [7:0]        w_store_byte;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_req_io_full = (bus.addr[17:16] == IO_HI) && bus.io_buffer_full;
    assign w_store_stall = (r_base[17:16] == IO_HI) && bus.io_buffer_full;
    // r_cnt counts edges since accept, so the byte arriving now is index r_cnt-1
    assign w_cap_idx     = r_cnt[1:0] - 2'd1;
    assign w_store_byte  = r_store_val[{r_cnt[1:0], 3'b000} +: 8];
    assign w_next_addr   = r_base + ADDR_W'(r_cnt);

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [3:0] t);
        logic [31:0] v;
        unique case (t)
            LS_LB:   v = {{24{raw[7]}}, raw[7:0]};
            LS_LH:   v = {{16{raw[15]}}, raw[15:0]};
            LS_LBU:  v = {24'b0, raw[7:0]};
            LS_LHU:  v = {16'b0, raw[15:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= StIdle;
            r_base        <= '0;
            r_mem_a       <= '0;
            r_type        <= '0;
            r_store_val   <= '0;
            r_data        <= '0;
            r_load_val    <= '0;
            r_if_data     <= '0;
            r_cnt         <= '0;
            r_len         <= '0;
            r_mem_dout    <= '0;
            r_mem_wr      <= 1'b0;
            r_ls_finished <= 1'b0;
            r_if_done     <= 1'b0;
            r_flush       <= 1'b0;
        end else if (rdy_in) begin
            r_ls_finished <= 1'b0;
            r_if_done     <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (!clear) begin
                        if (bus.ls_enable) begin
                            r_base      <= bus.addr;
                            r_type      <= bus.lsb_type;
                            r_store_val <= bus.store_val;
                            r_len       <= byte_count(bus.lsb_type[1:0]);
                            r_data      <= '0;
                            r_mem_a     <= bus.addr;
                            if (is_store(bus.lsb_type)) begin
                                r_state <= StStore;
                                if (w_req_io_full) begin
                                    r_mem_wr <= 1'b0;
                                    r_cnt    <= 3'd0;
                                end else begin
                                    r_mem_wr   <= 1'b1;
                                    r_mem_dout <= bus.store_val[7:0];
                                    r_cnt      <= 3'd1;
                                end
                            end else begin
                                r_state <= StLoad;
                                r_cnt   <= 3'd1;
                            end
                        end else if (bus.if_enable) begin
                            r_base  <= bus.if_addr;
                            r_len   <= 3'd4;
                            r_data  <= '0;
                            r_mem_a <= bus.if_addr;
                            r_cnt   <= 3'd1;
                            r_state <= StFetch;
                        end
                    end
                end

                StLoad, StFetch: begin
                    if (clear) begin
                        r_state <= StIdle;
                        r_mem_a <= '0;
                    end else if (r_cnt == r_len + 3'd1) begin
                        r_state <= StIdle;
                        if (r_state == StFetch) begin
                            r_if_done <= 1'b1;
                            r_if_data <= r_data;
                        end else begin
                            r_ls_finished <= 1'b1;
                            r_load_val    <= extend_load(r_data, r_type);
                        end
                    end else begin
                        r_data[{w_cap_idx, 3'b000} +: 8] <= bus.mem_din;
                        r_cnt   <= r_cnt + 3'd1;
                        r_mem_a <= (r_cnt == r_len) ? '0 : w_next_addr;
                    end
                end

                StStore: begin
                    // A committed store always drains; clear only hides its completion
                    if (clear) begin
                        r_flush <= 1'b1;
                    end
                    if (r_cnt == r_len) begin
                        r_mem_wr      <= 1'b0;
                        r_mem_a       <= '0;
                        r_ls_finished <= !(clear || r_flush);
                        r_flush       <= 1'b0;
                        r_state       <= StIdle;
                    end else if (w_store_stall) begin
                        r_mem_wr <= 1'b0;
                    end else begin
                        r_mem_wr   <= 1'b1;
                        r_mem_a    <= w_next_addr;
                        r_mem_dout <= w_store_byte;
                        r_cnt      <= r_cnt + 3'd1;
                    end
                end

                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.mem_a       = r_mem_a;
    assign bus.mem_dout    = r_mem_dout;
    assign bus.mem_wr      = r_mem_wr;
    assign bus.ls_finished = r_ls_finished;
    assign bus.load_val    = r_load_val;
    assign bus.if_done     = r_if_done;
    assign bus.if_data     = r_if_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus randomized accesses checked against
// a byte-array RAM and an arithmetic load/store model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rdy   = 1'b1;
    logic clear = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  ram [0:65535];
    logic [39:0] wlog [$];
    logic [31:0] trace [0:31];

    mem_ctrl_if #(.ADDR_W(32)) bif ();

    mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .clear  (clear),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    // RAM read data for the address presented this cycle; low 16 bits index the array
    assign bif.mem_din = ram[bif.mem_a[15:0]];

    always @(posedge clk) begin
        if (!rst && rdy && bif.mem_wr) wlog.push_back({bif.mem_a, bif.mem_dout});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int access_bytes(input logic [3:0] t);
        case (t)
            LS_LB, LS_LBU, LS_SB: return 1;
            LS_LH, LS_LHU, LS_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    // Little-endian gather of n bytes, then two's-complement reinterpretation for LB/LH
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] t);
        int          n;
        longint      v;
        logic [31:0] ak;
        n = access_bytes(t);
        v = 0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            v  = v + (longint'(ram[ak[15:0]]) << (8 * k));
        end
        if ((t == LS_LB || t == LS_LH) && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Drives one request, waits (bounded) for its completion; lat = edges after accept, -1 on timeout
    task automatic run_access(input bit fetch, input logic [31:0] a, input logic [3:0] t,
                              input logic [31:0] sv, output int lat, output logic [31:0] val);
        wlog.delete();
        if (fetch) begin
            bif.if_enable = 1'b1;
            bif.if_addr   = a;
        end else begin
            bif.ls_enable = 1'b1;
            bif.addr      = a;
            bif.lsb_type  = t;
            bif.store_val = sv;
        end
        tick();
        trace[0]      = bif.mem_a;
        bif.ls_enable = 1'b0;
        bif.if_enable = 1'b0;
        lat = -1;
        val = 'x;
        for (int k = 1; k <= 20; k++) begin
            tick();
            trace[k] = bif.mem_a;
            if (fetch ? bif.if_done : bif.ls_finished) begin
                lat = k;
                val = fetch ? bif.if_data : bif.load_val;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (bif.mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a got=%h exp=0", bif.mem_a); end
        total++; if (bif.mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b exp=0", bif.mem_wr); end
        total++; if (bif.mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout got=%h exp=0", bif.mem_dout); end
        total++; if ({bif.ls_finished, bif.if_done} !== 2'b00) begin bad++;
            $display("FAIL reset_done got=%b exp=00", {bif.ls_finished, bif.if_done}); end
        total++; if ({bif.load_val, bif.if_data} !== 64'h0) begin bad++;
            $display("FAIL reset_data got=%h exp=0", {bif.load_val, bif.if_data}); end
        rst = 1'b0;
        tick();
        tick();
        total++; if ({bif.mem_wr, bif.ls_finished, bif.if_done} !== 3'b000) begin bad++;
            $display("FAIL idle_quiet got=%b exp=000", {bif.mem_wr, bif.ls_finished, bif.if_done}); end
    endtask

    task automatic test_load_word();
        int          lat;
        logic [31:0] val;
        run_access(1'b0, 32'h100, LS_LW, 32'h0, lat, val);
        total++; if (lat !== 5) begin bad++; $display("FAIL lw_latency got=%0d exp=5", lat); end
        total++; if (val !== 32'h12345678) begin bad++; $display("FAIL lw_value got=%h exp=12345678", val); end
        for (int k = 0; k < 4; k++) begin
            total++; if (trace[k] !== 32'h100 + 32'(k)) begin bad++;
                $display("FAIL lw_addr_%0d got=%h exp=%h", k, trace[k], 32'h100 + 32'(k)); end
        end
        total++; if (trace[4] !== 32'h0) begin bad++; $display("FAIL lw_addr_return got=%h exp=0", trace[4]); end
    endtask

    task automatic test_load_byte();
        int          lat;
        logic [31:0] val;
        run_access(1'b0, 32'h200, LS_LB, 32'h0, lat, val);
        total++; if (lat !== 2) begin bad++; $display("FAIL lb_latency got=%0d exp=2", lat); end
        total++; if (val !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_value got=%h exp=ffffff80", val); end
        run_access(1'b0, 32'h200, LS_LBU, 32'h0, lat, val);
        total++; if (lat !== 2) begin bad++; $display("FAIL lbu_latency got=%0d exp=2", lat); end
        total++; if (val !== 32'h00000080) begin bad++; $display("FAIL lbu_value got=%h exp=00000080", val); end
        run_access(1'b0, 32'h200, LS_LH, 32'h0, lat, val);
        total++; if (val !== 32'hFFFF9A80) begin bad++; $display("FAIL lh_value got=%h exp=ffff9a80", val); end
        run_access(1'b0, 32'h200, LS_LHU, 32'h0, lat, val);
        total++; if (val !== 32'h00009A80) begin bad++; $display("FAIL lhu_value got=%h exp=00009a80", val); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] val;
        run_access(1'b0, 32'h300, LS_SH, 32'h1234ABCD, lat, val);
        total++; if (lat !== 2) begin bad++; $display("FAIL sh_latency got=%0d exp=2", lat); end
        total++; if (wlog.size() !== 2) begin bad++; $display("FAIL sh_count got=%0d exp=2", wlog.size()); end
        else begin
            total++; if (wlog[0] !== {32'h300, 8'hCD}) begin bad++; $display("FAIL sh_byte0 got=%h exp=300cd", wlog[0]); end
            total++; if (wlog[1] !== {32'h301, 8'hAB}) begin bad++; $display("FAIL sh_byte1 got=%h exp=301ab", wlog[1]); end
        end
        // Next request presented during the completion pulse
        run_access(1'b0, 32'h200, LS_LBU, 32'h0, lat, val);
        total++; if (trace[0] !== 32'h200) begin bad++; $display("FAIL b2b_accept got=%h exp=200", trace[0]); end
        total++; if (val !== 32'h80) begin bad++; $display("FAIL b2b_value got=%h exp=80", val); end
    endtask

    task automatic test_arbitration();
        int got;
        bif.ls_enable = 1'b1; bif.addr = 32'h100; bif.lsb_type = LS_LW;
        bif.if_enable = 1'b1; bif.if_addr = 32'h400;
        tick();
        total++; if (bif.mem_a !== 32'h100) begin bad++; $display("FAIL arb_lsb_first got=%h exp=100", bif.mem_a); end
        bif.ls_enable = 1'b0;
        got = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bif.ls_finished) begin got = k; break; end
        end
        total++; if (got !== 5) begin bad++; $display("FAIL arb_lsb_latency got=%0d exp=5", got); end
        total++; if (bif.load_val !== 32'h12345678) begin bad++; $display("FAIL arb_lsb_value got=%h exp=12345678", bif.load_val); end
        tick();
        total++; if (bif.mem_a !== 32'h400) begin bad++; $display("FAIL arb_fetch_start got=%h exp=400", bif.mem_a); end
        bif.if_enable = 1'b0;
        got = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bif.if_done) begin got = k; break; end
        end
        total++; if (got !== 5) begin bad++; $display("FAIL arb_fetch_latency got=%0d exp=5", got); end
        total++; if (bif.if_data !== model_load(32'h400, LS_LW)) begin bad++;
            $display("FAIL arb_fetch_data got=%h exp=%h", bif.if_data, model_load(32'h400, LS_LW)); end
    endtask

    task automatic test_clear();
        bit          seen;
        bit          err;
        int          lat;
        logic [31:0] val;
        logic [31:0] sw_val;
        bif.ls_enable = 1'b1; bif.addr = 32'h100; bif.lsb_type = LS_LW;
        tick();
        bif.ls_enable = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (bif.mem_a !== 32'h0) begin bad++; $display("FAIL clr_load_addr got=%h exp=0", bif.mem_a); end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin seen |= bif.ls_finished; tick(); end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL clr_load_done got=%b exp=0", seen); end

        // No acceptance on the clear edge, acceptance on the next one
        bif.ls_enable = 1'b1; bif.addr = 32'h200; bif.lsb_type = LS_LB; clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (bif.mem_a !== 32'h0) begin bad++; $display("FAIL clr_no_accept got=%h exp=0", bif.mem_a); end
        tick();
        bif.ls_enable = 1'b0;
        total++; if (bif.mem_a !== 32'h200) begin bad++; $display("FAIL clr_then_accept got=%h exp=200", bif.mem_a); end
        tick();
        tick();
        total++; if (bif.ls_finished !== 1'b1 || bif.load_val !== 32'hFFFFFF80) begin bad++;
            $display("FAIL clr_then_load got=%b/%h exp=1/ffffff80", bif.ls_finished, bif.load_val); end

        sw_val = 32'hDEADBEEF;
        wlog.delete();
        bif.ls_enable = 1'b1; bif.addr = 32'h500; bif.lsb_type = LS_SW; bif.store_val = sw_val;
        tick();
        bif.ls_enable = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin seen |= bif.ls_finished; tick(); end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL clr_store_done got=%b exp=0", seen); end
        err = (wlog.size() != 4);
        for (int k = 0; k < 4 && k < wlog.size(); k++)
            if (wlog[k] !== {32'h500 + 32'(k), 8'((sw_val >> (8 * k)) & 32'hFF)}) err = 1'b1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL clr_store_bytes got=%0d writes exp=4 exact", wlog.size()); end
        run_access(1'b0, 32'h510, LS_SB, 32'h5A, lat, val);
        total++; if (lat !== 1) begin bad++; $display("FAIL clr_store_after got=%0d exp=1", lat); end
    endtask

    task automatic test_io_stall();
        int          lat;
        logic [31:0] val;
        wlog.delete();
        bif.io_buffer_full = 1'b1;
        bif.ls_enable = 1'b1; bif.addr = 32'h30000; bif.lsb_type = LS_SB; bif.store_val = 32'hA5;
        tick();
        bif.ls_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (bif.mem_wr !== 1'b0) begin bad++; $display("FAIL io_stall_%0d got=%b exp=0", k, bif.mem_wr); end
            if (k < 2) tick();
        end
        bif.io_buffer_full = 1'b0;
        tick();
        total++; if ({bif.mem_wr, bif.mem_a, bif.mem_dout} !== {1'b1, 32'h30000, 8'hA5}) begin bad++;
            $display("FAIL io_write got=%b/%h/%h exp=1/00030000/a5", bif.mem_wr, bif.mem_a, bif.mem_dout); end
        tick();
        total++; if ({bif.ls_finished, bif.mem_wr} !== 2'b10) begin bad++;
            $display("FAIL io_done got=%b exp=10", {bif.ls_finished, bif.mem_wr}); end
        total++; if (wlog.size() !== 1) begin bad++; $display("FAIL io_count got=%0d exp=1", wlog.size()); end
        // Full flag does not affect stores outside the IO region
        bif.io_buffer_full = 1'b1;
        run_access(1'b0, 32'h20000, LS_SB, 32'h11, lat, val);
        bif.io_buffer_full = 1'b0;
        total++; if (lat !== 1) begin bad++; $display("FAIL non_io_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_wrap_and_ready();
        int          lat;
        logic [31:0] val;
        run_access(1'b0, 32'hFFFFFFFE, LS_LW, 32'h0, lat, val);
        total++; if ({trace[1], trace[2], trace[3]} !== {32'hFFFFFFFF, 32'h0, 32'h1}) begin bad++;
            $display("FAIL wrap_addr got=%h %h %h exp=ffffffff 0 1", trace[1], trace[2], trace[3]); end
        total++; if (val !== model_load(32'hFFFFFFFE, LS_LW)) begin bad++;
            $display("FAIL wrap_value got=%h exp=%h", val, model_load(32'hFFFFFFFE, LS_LW)); end
        bif.ls_enable = 1'b1; bif.addr = 32'h100; bif.lsb_type = LS_LW;
        tick();
        bif.ls_enable = 1'b0;
        tick();
        rdy = 1'b0;
        tick(); tick(); tick();
        total++; if ({bif.mem_a, bif.ls_finished} !== {32'h101, 1'b0}) begin bad++;
            $display("FAIL rdy_freeze got=%h/%b exp=101/0", bif.mem_a, bif.ls_finished); end
        rdy = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bif.ls_finished) begin lat = k; break; end
        end
        total++; if (lat !== 4 || bif.load_val !== 32'h12345678) begin bad++;
            $display("FAIL rdy_resume got=%0d/%h exp=4/12345678", lat, bif.load_val); end
    endtask

    task automatic test_random();
        logic [3:0]  kinds [0:7];
        logic [3:0]  t;
        logic [31:0] a, sv, val, ak, exp_val;
        int          sel, lat, nb;
        bit          err;
        kinds[0] = LS_LB; kinds[1] = LS_LH; kinds[2] = LS_LW; kinds[3] = LS_LBU;
        kinds[4] = LS_LHU; kinds[5] = LS_SB; kinds[6] = LS_SH; kinds[7] = LS_SW;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 8);
            a   = $urandom;
            sv  = $urandom;
            t   = (sel == 8) ? LS_LW : kinds[sel];
            nb  = access_bytes(t);
            exp_val = model_load(a, t);
            run_access(sel == 8, a, t, sv, lat, val);
            if (sel == 8 || !t[3]) begin
                total++; if (lat !== nb + 1 || val !== exp_val) begin bad++;
                    $display("FAIL rand_load_%0d t=%b a=%h got=%0d/%h exp=%0d/%h", i, t, a, lat, val, nb + 1, exp_val); end
            end else begin
                err = (wlog.size() != nb) || (lat != nb);
                for (int k = 0; k < nb && k < wlog.size(); k++) begin
                    ak = a + 32'(k);
                    if (wlog[k] !== {ak, 8'((sv >> (8 * k)) & 32'hFF)}) err = 1'b1;
                end
                total++; if (err !== 1'b0) begin bad++;
                    $display("FAIL rand_store_%0d t=%b a=%h got=%0d writes lat=%0d exp=%0d", i, t, a, wlog.size(), lat, nb); end
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        wlog.delete();
        bif.ls_enable = 1'b1; bif.addr = 32'h600; bif.lsb_type = LS_SW; bif.store_val = 32'h01020304;
        tick();
        bif.ls_enable = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++; if ({bif.mem_wr, bif.mem_a} !== {1'b0, 32'h0}) begin bad++;
            $display("FAIL rst_mid got=%b/%h exp=0/0", bif.mem_wr, bif.mem_a); end
        tick();
        rst = 1'b0;
        wlog.delete();
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin seen |= bif.ls_finished | bif.mem_wr; tick(); end
        total++; if (seen !== 1'b0 || wlog.size() !== 0) begin bad++;
            $display("FAIL rst_no_replay got=%b/%0d exp=0/0", seen, wlog.size()); end
    endtask

    initial begin
        bif.ls_enable = 1'b0; bif.addr = '0; bif.store_val = '0; bif.lsb_type = '0;
        bif.if_enable = 1'b0; bif.if_addr = '0; bif.io_buffer_full = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        ram[16'h100] = 8'h78; ram[16'h101] = 8'h56; ram[16'h102] = 8'h34; ram[16'h103] = 8'h12;
        ram[16'h200] = 8'h80; ram[16'h201] = 8'h9A;
        test_reset();
        test_load_word();
        test_load_byte();
        test_back_to_back();
        test_arbitration();
        test_clear();
        test_io_stall();
        test_wrap_and_ready();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
